// File: rtl/mips_pkg.sv
// Shared widths and types for the dual-issue pipeline datapath.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_bypass_mux.sv
// One register-file read port: zero / WB lane1 / WB lane0 / array priority select.
module regfile_bypass_mux
  import mips_pkg::*;
(
  input  reg_addr_t ra_i,
  input  logic      we0_i,
  input  reg_addr_t wa0_i,
  input  word_t     wd0_i,
  input  logic      we1_i,
  input  reg_addr_t wa1_i,
  input  word_t     wd1_i,
  input  word_t     arr_i,
  output word_t     rdata_c_o,
  output logic      wr_hit_c_o
);

  logic hit0_c;
  logic hit1_c;

  always_comb begin
    hit0_c     = we0_i && (wa0_i == ra_i);
    hit1_c     = we1_i && (wa1_i == ra_i);
    wr_hit_c_o = hit0_c || hit1_c;
    rdata_c_o  = arr_i;
    if (ra_i == REG_ZERO) begin
      rdata_c_o = '0;
    end else if (hit1_c) begin
      rdata_c_o = wd1_i;
    end else if (hit0_c) begin
      rdata_c_o = wd0_i;
    end
  end

endmodule

// File: rtl/regfile_wb_2w4r.sv
// Architectural register file: 2 WB write lanes, 4 bypassed read ports, busy scoreboard.
module regfile_wb_2w4r
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  reg_addr_t ra0,
  input  reg_addr_t ra1,
  input  reg_addr_t ra2,
  input  reg_addr_t ra3,
  output word_t     rdata0,
  output word_t     rdata1,
  output word_t     rdata2,
  output word_t     rdata3,
  output logic      busy0,
  output logic      busy1,
  output logic      busy2,
  output logic      busy3,
  input  logic      we0,
  input  logic      we1,
  input  reg_addr_t wa0,
  input  reg_addr_t wa1,
  input  word_t     wd0,
  input  word_t     wd1,
  input  logic      iss0_v,
  input  logic      iss1_v,
  input  reg_addr_t iss0_rd,
  input  reg_addr_t iss1_rd,
  input  logic      flush
);

  localparam int unsigned NPORT = 4;

  word_t             regs_q [NREG];
  word_t             regs_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  reg_addr_t ra_a      [NPORT];
  word_t     rdata_a   [NPORT];
  logic      wr_hit_a  [NPORT];
  logic      busy_a    [NPORT];

  // Lane1 is younger, so it is applied last and wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (we0 && (wa0 == reg_addr_t'(r))) regs_d[r] = wd0;
      if (we1 && (wa1 == reg_addr_t'(r))) regs_d[r] = wd1;
    end
    regs_d[0] = '0;
  end

  // Issue set beats write-back clear: the issuing producer is younger.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if ((iss0_v && (iss0_rd == reg_addr_t'(r))) ||
                   (iss1_v && (iss1_rd == reg_addr_t'(r)))) begin
        busy_d[r] = 1'b1;
      end else if ((we0 && (wa0 == reg_addr_t'(r))) ||
                   (we1 && (wa1 == reg_addr_t'(r)))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign ra_a[0] = ra0;
  assign ra_a[1] = ra1;
  assign ra_a[2] = ra2;
  assign ra_a[3] = ra3;

  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    regfile_bypass_mux u_mux (
      .ra_i       (ra_a[p]),
      .we0_i      (we0),
      .wa0_i      (wa0),
      .wd0_i      (wd0),
      .we1_i      (we1),
      .wa1_i      (wa1),
      .wd1_i      (wd1),
      .arr_i      (regs_q[ra_a[p]]),
      .rdata_c_o  (rdata_a[p]),
      .wr_hit_c_o (wr_hit_a[p])
    );
    // Data is bypassed this cycle, so the pending producer no longer stalls.
    assign busy_a[p] = busy_q[ra_a[p]] && !wr_hit_a[p];
  end

  assign rdata0 = rdata_a[0];
  assign rdata1 = rdata_a[1];
  assign rdata2 = rdata_a[2];
  assign rdata3 = rdata_a[3];
  assign busy0  = busy_a[0];
  assign busy1  = busy_a[1];
  assign busy2  = busy_a[2];
  assign busy3  = busy_a[3];

  // Decode contract: no second producer while one is in flight (WAW stall).
  logic waw_c;
  always_comb begin
    waw_c = 1'b0;
    if (iss0_v && (iss0_rd != REG_ZERO) && busy_q[iss0_rd] &&
        !((we0 && (wa0 == iss0_rd)) || (we1 && (wa1 == iss0_rd)))) waw_c = 1'b1;
    if (iss1_v && (iss1_rd != REG_ZERO) && busy_q[iss1_rd] &&
        !((we0 && (wa0 == iss1_rd)) || (we1 && (wa1 == iss1_rd)))) waw_c = 1'b1;
    if (iss0_v && iss1_v && (iss0_rd != REG_ZERO) && (iss0_rd == iss1_rd)) waw_c = 1'b1;
  end

  a_no_waw: assert property (@(posedge clk) disable iff (reset || flush) !waw_c);

endmodule

// File: tb/tb_regfile_wb_2w4r.sv
// Directed bench for regfile_wb_2w4r with a queue of expected read-port values.
module tb_regfile_wb_2w4r;
  import mips_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  reg_addr_t ra0, ra1, ra2, ra3;
  word_t     rdata0, rdata1, rdata2, rdata3;
  logic      busy0, busy1, busy2, busy3;
  logic      we0, we1, iss0_v, iss1_v, flush;
  reg_addr_t wa0, wa1, iss0_rd, iss1_rd;
  word_t     wd0, wd1;

  typedef struct {
    string       tag;
    int unsigned port;
    logic        is_busy;
    word_t       exp;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_wb_2w4r dut (
    .clk(clk), .reset(reset),
    .ra0(ra0), .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
    .busy0(busy0), .busy1(busy1), .busy2(busy2), .busy3(busy3),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .iss0_v(iss0_v), .iss1_v(iss1_v), .iss0_rd(iss0_rd), .iss1_rd(iss1_rd),
    .flush(flush)
  );

  function automatic word_t observe(input int unsigned port, input logic is_busy);
    word_t d;
    logic  b;
    case (port)
      0: begin d = rdata0; b = busy0; end
      1: begin d = rdata1; b = busy1; end
      2: begin d = rdata2; b = busy2; end
      default: begin d = rdata3; b = busy3; end
    endcase
    return is_busy ? XLEN'(b) : d;
  endfunction

  task automatic exp_data(input string tag, input int unsigned port, input word_t v);
    exp_t e;
    e.tag = tag; e.port = port; e.is_busy = 1'b0; e.exp = v;
    q.push_back(e);
  endtask

  task automatic exp_busy(input string tag, input int unsigned port, input logic v);
    exp_t e;
    e.tag = tag; e.port = port; e.is_busy = 1'b1; e.exp = XLEN'(v);
    q.push_back(e);
  endtask

  // Let combinational outputs settle mid-cycle, then retire every queued expectation.
  task automatic check_now();
    exp_t  e;
    word_t obs;
    #2;
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = observe(e.port, e.is_busy);
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s port=%0d observed=%h expected=%h", e.tag, e.port, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    reset = 1'b0; we0 = 1'b0; we1 = 1'b0;
    iss0_v = 1'b0; iss1_v = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ra0 = '0; ra1 = '0; ra2 = '0; ra3 = '0;
    we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    iss0_v = 1'b0; iss1_v = 1'b0; iss0_rd = '0; iss1_rd = '0; flush = 1'b0;
    tick();

    // After reset every address reads zero and idle
    for (int a = 0; a < 32; a += 4) begin
      ra0 = reg_addr_t'(a); ra1 = reg_addr_t'(a + 1);
      ra2 = reg_addr_t'(a + 2); ra3 = reg_addr_t'(a + 3);
      for (int p = 0; p < 4; p++) begin
        exp_data("rst_data", p, '0);
        exp_busy("rst_busy", p, 1'b0);
      end
      check_now();
    end

    // Register 0 ignores writes, including via bypass
    ra0 = 5'd0; we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEADBEEF;
    exp_data("r0_bypass", 0, '0);
    check_now();
    tick();
    exp_data("r0_stored", 0, '0);
    check_now();

    // Same-cycle bypass then stored value
    ra0 = 5'd5; ra1 = 5'd5; we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1234;
    exp_data("wr5_bypass", 0, 32'h1234);
    check_now();
    tick();
    exp_data("wr5_stored0", 0, 32'h1234);
    exp_data("wr5_stored1", 1, 32'h1234);
    check_now();
    tick();
    exp_data("wr5_hold", 0, 32'h1234);
    check_now();

    // Dual write to same address: lane1 wins
    ra1 = 5'd7; we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hBBBB;
    exp_data("dual_bypass", 1, 32'hBBBB);
    check_now();
    tick();
    exp_data("dual_stored", 1, 32'hBBBB);
    check_now();

    // Issue marks busy next cycle; write-back masks and clears it
    ra2 = 5'd9; iss0_v = 1'b1; iss0_rd = 5'd9;
    exp_busy("iss9_same", 2, 1'b0);
    check_now();
    tick();
    exp_busy("iss9_next", 2, 1'b1);
    check_now();
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h99;
    exp_busy("wb9_mask", 2, 1'b0);
    exp_data("wb9_bypass", 2, 32'h99);
    check_now();
    tick();
    exp_busy("wb9_clear", 2, 1'b0);
    exp_data("wb9_stored", 2, 32'h99);
    check_now();

    // Issue beats same-cycle write-back clear on r3
    ra3 = 5'd3; iss0_v = 1'b1; iss0_rd = 5'd3;
    tick();
    exp_busy("r3_busy", 3, 1'b1);
    check_now();
    iss1_v = 1'b1; iss1_rd = 5'd3; we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h333;
    exp_busy("r3_mask", 3, 1'b0);
    exp_data("r3_bypass", 3, 32'h333);
    check_now();
    tick();
    exp_busy("r3_still_busy", 3, 1'b1);
    exp_data("r3_stored", 3, 32'h333);
    check_now();
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h444;
    tick();
    exp_busy("r3_cleared", 3, 1'b0);
    exp_data("r3_second", 3, 32'h444);
    check_now();

    // Flush clears busy and drops same-cycle issue
    ra0 = 5'd4; ra1 = 5'd6; ra2 = 5'd8;
    iss0_v = 1'b1; iss0_rd = 5'd4; iss1_v = 1'b1; iss1_rd = 5'd6;
    tick();
    exp_busy("pre_flush4", 0, 1'b1);
    exp_busy("pre_flush6", 1, 1'b1);
    check_now();
    flush = 1'b1; iss0_v = 1'b1; iss0_rd = 5'd8;
    tick();
    exp_busy("flush4", 0, 1'b0);
    exp_busy("flush6", 1, 1'b0);
    exp_busy("flush8", 2, 1'b0);
    check_now();

    // Mid-stream reset discards stored data, busy and same-cycle writes/issues
    iss0_v = 1'b1; iss0_rd = 5'd10;
    tick();
    reset = 1'b1; we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h5555;
    iss0_v = 1'b1; iss0_rd = 5'd11;
    tick();
    ra0 = 5'd5; ra1 = 5'd7; ra2 = 5'd10; ra3 = 5'd12;
    exp_data("mrst_r5", 0, '0);
    exp_data("mrst_r7", 1, '0);
    exp_busy("mrst_b10", 2, 1'b0);
    exp_data("mrst_r12", 3, '0);
    check_now();
    ra2 = 5'd11; ra3 = 5'd9;
    exp_busy("mrst_b11", 2, 1'b0);
    exp_data("mrst_r9", 3, '0);
    check_now();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
